// File: rtl/weapon_fire_scheduler_if.sv
// rtl/weapon_fire_scheduler_if.sv - fire request/grant/error bundle between turret logic and scheduler
interface weapon_fire_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic             reload_req;
    logic [N_REQ-1:0] grant;
    logic             error;

    modport master (
        output req,
        output reload_req,
        input  grant,
        input  error
    );

    modport slave (
        input  req,
        input  reload_req,
        output grant,
        output error
    );
endinterface

// File: rtl/weapon_fire_scheduler.sv
// rtl/weapon_fire_scheduler.sv - round-robin fire scheduler sharing one ammo pool, with reload and cooldown phases
// Optional shot/error statistics counters enabled by FIRE_STATS_EN.
module weapon_fire_scheduler #(
    parameter int N_REQ  = 4,
    parameter int AMMO_W = 9,
    parameter int COOL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mode,
    weapon_fire_scheduler_if.slave fire_bus,
    input  logic [AMMO_W-1:0] reload_amt,
    input  logic [AMMO_W-1:0] max_ammo,
    input  logic [AMMO_W-1:0] fire_cost,
    input  logic [COOL_W-1:0] cooldown,
    output logic [AMMO_W-1:0] ammo,
    output logic              busy,
    output logic [1:0]        state
`ifdef FIRE_STATS_EN
    ,
    output logic [15:0]       shot_count,
    output logic [7:0]        err_count
`endif
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        RELOAD   = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [AMMO_W-1:0] ammo_q, ammo_n;
    logic [COOL_W-1:0] cnt_q, cnt_n;
    logic [PTR_W-1:0]  ptr_q, ptr_n;
    logic [N_REQ-1:0]  grant_q, grant_n;
    logic              error_q, error_n;

    logic              attack;
    logic              any_req;
    logic              clamp;
    logic [AMMO_W-1:0] eff_cost;
    logic [AMMO_W:0]   reload_sum;
    logic [AMMO_W-1:0] reload_sat;
    logic              pick_found;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  pick_next;

    assign attack     = (mode == 4'b0010);
    assign any_req    = |fire_bus.req;
    assign clamp      = (max_ammo < ammo_q);
    assign eff_cost   = (fire_cost == '0) ? AMMO_W'(1) : fire_cost;
    // One extra bit keeps the reload sum from wrapping before saturation.
    assign reload_sum = {1'b0, ammo_q} + {1'b0, reload_amt};
    assign reload_sat = (reload_sum > {1'b0, max_ammo}) ? max_ammo : reload_sum[AMMO_W-1:0];

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(ptr_q) + i) % N_REQ;
            if (!pick_found && fire_bus.req[j]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
        pick_next = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end

    always_comb begin
        state_n = state_q;
        ammo_n  = ammo_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        grant_n = '0;
        error_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_bus.reload_req && (ammo_q < max_ammo)) begin
                    state_n = RELOAD;
                end else if (any_req) begin
                    if (attack && (ammo_q >= eff_cost) && !clamp && pick_found) begin
                        grant_n = N_REQ'(1) << pick_idx;
                        ammo_n  = ammo_q - eff_cost;
                        ptr_n   = pick_next;
                        if (cooldown != '0) begin
                            state_n = COOLDOWN;
                            cnt_n   = cooldown;
                        end
                    end else if (!attack || (ammo_q < eff_cost)) begin
                        error_n = 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (cnt_q <= COOL_W'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q - COOL_W'(1);
                end
            end
            RELOAD: begin
                error_n = any_req;
                if (!fire_bus.reload_req) begin
                    state_n = IDLE;
                end else begin
                    ammo_n = reload_sat;
                    if (reload_sat == max_ammo) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (clamp) begin
            ammo_n = max_ammo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ammo_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_n;
            ammo_q  <= ammo_n;
            cnt_q   <= cnt_n;
            ptr_q   <= ptr_n;
            grant_q <= grant_n;
            error_q <= error_n;
        end
    end

`ifdef FIRE_STATS_EN
    logic [15:0] shot_q;
    logic [7:0]  errc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shot_q <= '0;
            errc_q <= '0;
        end else begin
            if ((grant_n != '0) && (shot_q != 16'hFFFF)) begin
                shot_q <= shot_q + 16'd1;
            end
            if (error_n && (errc_q != 8'hFF)) begin
                errc_q <= errc_q + 8'd1;
            end
        end
    end

    assign shot_count = shot_q;
    assign err_count  = errc_q;
`endif

    assign ammo           = ammo_q;
    assign state          = state_q;
    assign busy           = (state_q != IDLE);
    assign fire_bus.grant = grant_q;
    assign fire_bus.error = error_q;
endmodule

// File: doc/weapon_fire_scheduler.md
Name: weapon_fire_scheduler

Overview:
Fire-control scheduler that shares one ammunition pool between N_REQ turret requesters. It round-robin arbitrates fire requests and gates them on attack mode and remaining ammo. It sequences reload and post-shot cooldown phases. It sits between the turret/command logic and the ammo datapath, owns the ammo count, and reports misuse on `error`.

Parameters:
N_REQ, 4, number of turret requesters (2..8)
AMMO_W, 9, ammo count width
COOL_W, 8, cooldown counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
mode  input  4  operating mode; 4'b0010 = attack, any other value = not attack
req  input  N_REQ  level fire requests, one bit per turret
reload_req  input  1  level request to reload the pool
reload_amt  input  AMMO_W  ammo added per reload cycle
max_ammo  input  AMMO_W  pool capacity
fire_cost  input  AMMO_W  ammo consumed per shot; value 0 is treated as 1
cooldown  input  COOL_W  cycles spent in COOLDOWN after each shot
grant  output  N_REQ  registered one-hot shot pulse, 1 cycle
ammo  output  AMMO_W  current pool count
busy  output  1  high when state is not IDLE
state  output  2  IDLE=0, COOLDOWN=1, RELOAD=2
error  output  1  registered 1-cycle misuse pulse

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-reload or mid-cooldown) sets state=IDLE, ammo=0, grant=0, error=0, the cooldown counter to 0 and the RR pointer to 0. Reset takes priority over all other inputs.
- Definitions: eff_cost = (fire_cost==0) ? 1 : fire_cost; attack = (mode==4'b0010).
- All outputs are registered. A decision sampled at edge k appears on outputs after edge k.
- IDLE:
  - If reload_req=1 and ammo<max_ammo: go to RELOAD. Any req is ignored in that cycle and no error is raised.
  - Otherwise, if |req and attack and ammo>=eff_cost:
    - Grant the first set req bit at or after the RR pointer, wrapping from N_REQ-1 to 0.
    - grant = that bit for 1 cycle; ammo -= eff_cost.
    - The pointer becomes (granted index+1) mod N_REQ.
    - Go to COOLDOWN with counter=cooldown. If cooldown==0, stay in IDLE instead; the next grant is then possible on the following edge.
  - Otherwise, if |req and (!attack or ammo<eff_cost): error=1 for 1 cycle, no grant, ammo unchanged.
- COOLDOWN:
  - The counter decrements each cycle. When the counter==1 at an edge, go to IDLE.
  - req and reload_req are ignored, with no error.
  - A mode change does not abort cooldown.
- RELOAD:
  - Each cycle ammo = min(ammo+reload_amt, max_ammo). The addition is computed at AMMO_W+1 bits, so it never wraps.
  - Exit to IDLE on the edge where the saturated result equals max_ammo, or when reload_req=0 (in that case ammo is unchanged that cycle).
  - If |req while in RELOAD: error=1 (firing while reloading is illegal), no grant.
- Clamp: if max_ammo < ammo in any state, ammo = max_ammo on the next edge. The clamp takes priority over fire and reload updates.
- ammo never underflows; a shot requires ammo>=eff_cost.
- grant is always zero or one-hot. At most one grant per cycle.
- busy = (state!=IDLE). state encoding 3 is unreachable; if entered, go to IDLE.

Optional Feature:
FIRE_STATS_EN:
- Defined: adds output shot_count[15:0], which increments on every grant and saturates at 16'hFFFF. Reset clears it to 0. It also adds output err_count[7:0], which increments on every error pulse and saturates at 8'hFF.
- Undefined: neither port nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset/reload: rst 1 cycle; max_ammo=20, reload_amt=8, hold reload_req -> ammo 0 -> 8 -> 16 -> 20, then state=IDLE, busy=0. Asserting rst mid-RELOAD gives ammo=0 and state=IDLE next edge.
- Round-robin: ammo=20, mode=0010, fire_cost=3, cooldown=2, req=4'b1011 held -> grants 0001, 0010, 1000, 0001 (each followed by 2 COOLDOWN cycles). ammo goes 17, 14, 11, 8, and error stays 0.
- Wrong mode: mode=0001, req=0100, ammo=10 -> error=1 for 1 cycle, grant=0, ammo=10.
- Empty pool: mode=0010, fire_cost=5, ammo=4, req=0001 -> error pulse, no grant. Set fire_cost=0 with ammo=4 -> grant 0001, ammo=3.
- Conflicts: in IDLE with ammo<max, assert reload_req and req=0001 together -> state=RELOAD, no grant, no error. Any req during RELOAD -> error pulse.
- Clamp/zero cooldown: ammo=20, drop max_ammo to 12 -> ammo=12 next edge. cooldown=0 with req=0001 held -> grant 0001 on consecutive cycles until ammo<eff_cost, then an error pulse each cycle.
